coin_collector: RTL

COIN_COLLECTOR -- requirements
Module: coin_collector

---
 rtl/coin_collector.sv | 105 ++++++++++
 1 files changed

// File: rtl/coin_collector.sv
// Coin pickup and banking controller: arms a coin per level, detects player/coin
// overlap on frame edges, and banks the coin when the goal is reached.
module coin_collector #(
  parameter int HIT_MARGIN = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] PlayerS,
  input  logic [9:0] CoinX,
  input  logic [9:0] CoinY,
  input  logic [9:0] CoinS,
  input  logic       Level1_Active,
  input  logic       Level2_Active,
  input  logic       Level3_Active,
  input  logic       Player_Death,
  input  logic       Goal_Reached,
  output logic       Coin_Visible,
  output logic       Exit_Enable,
  output logic       Collect_Pulse,
  output logic       Level_Done,
  output logic [3:0] Total_Coins
);

  typedef enum logic [1:0] {IDLE, ARMED, COLLECTED, BANKED} state_t;

  localparam logic [10:0] MARGIN = 11'(HIT_MARGIN);

  state_t             state;
  logic               frame_q;
  logic [2:0]         lvl_q;
  logic [2:0]         lvl;
  logic               frame_edge;
  logic               lvl_change;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [10:0]        adx;
  logic [10:0]        ady;
  logic [10:0]        reach;
  logic               overlap;

  function automatic logic [10:0] abs11(input logic signed [10:0] d);
    return d[10] ? 11'(-d) : 11'(d);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'd15) ? c : c + 4'd1;
  endfunction

  // 11-bit signed differences cover the full -1023..1023 range of 10-bit coordinates.
  assign dx         = $signed({1'b0, PlayerX}) - $signed({1'b0, CoinX});
  assign dy         = $signed({1'b0, PlayerY}) - $signed({1'b0, CoinY});
  assign adx        = abs11(dx);
  assign ady        = abs11(dy);
  assign reach      = {1'b0, PlayerS} + {1'b0, CoinS} + MARGIN;
  assign overlap    = (adx <= reach) && (ady <= reach);
  assign lvl        = {Level3_Active, Level2_Active, Level1_Active};
  assign lvl_change = (lvl != lvl_q);
  assign frame_edge = frame_clk && !frame_q;

  assign Coin_Visible = (state == ARMED);
  assign Exit_Enable  = (state == COLLECTED);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      frame_q       <= 1'b0;
      lvl_q         <= 3'b000;
      Collect_Pulse <= 1'b0;
      Level_Done    <= 1'b0;
      Total_Coins   <= 4'd0;
    end else begin
      frame_q       <= frame_clk;
      lvl_q         <= lvl;
      Collect_Pulse <= 1'b0;
      Level_Done    <= 1'b0;
      // A level switch re-arms (or idles) regardless of where the coin currently is.
      if (lvl_change) begin
        state <= (lvl != 3'b000) ? ARMED : IDLE;
      end else begin
        case (state)
          ARMED: begin
            if (frame_edge && overlap && !Player_Death) begin
              state         <= COLLECTED;
              Collect_Pulse <= 1'b1;
            end
          end
          COLLECTED: begin
            if (Player_Death) begin
              state <= ARMED;
            end else if (Goal_Reached) begin
              state       <= BANKED;
              Level_Done  <= 1'b1;
              Total_Coins <= sat_inc(Total_Coins);
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
